// File: rtl/fspill_pkg.sv
// Shared definitions for the frame spill unit: frame geometry, the FSM
// state type, the memory request payload and the spill-area address helper.
package fspill_pkg;

  localparam int unsigned FRAME_WORDS = 16;
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned FRAME_W     = FRAME_WORDS * WORD_W;
  localparam int unsigned WORD_IDX_W  = $clog2(FRAME_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    SPILL,
    PUSH,
    FILL,
    FILL_WAIT
  } state_t;

  // Registered memory-port payload.
  typedef struct packed {
    logic              we;
    logic              re;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

  // Word address of word 'word' of spilled frame number 'frame_no' (1-based).
  // The spill area grows downward from 'base'.
  function automatic logic [WORD_W-1:0] spill_addr(
    input logic [WORD_W-1:0]     base,
    input logic [WORD_W-1:0]     frame_no,
    input logic [WORD_IDX_W-1:0] word
  );
    return base - (frame_no << 4) + {12'b0, word};
  endfunction

  // Word k of a frame.
  function automatic logic [WORD_W-1:0] frame_word(
    input logic [FRAME_W-1:0]    f,
    input logic [WORD_IDX_W-1:0] k
  );
    return f[{k, 4'b0000} +: WORD_W];
  endfunction

endpackage

// File: rtl/frame_lifo.sv
// DEPTH-slot circular frame store used as a LIFO with an extra port that
// exposes (and can retire) the oldest entry.
//   push     : write wdata at head, head+1, cnt+1
//   pop      : head-1, cnt-1 (newest_c holds the frame being popped)
//   replace  : when full, overwrite the oldest slot with wdata; head+1, tail+1
//   newest_c : frame at head-1 (combinational)
//   oldest_c : frame at tail (combinational)
//   cnt      : number of occupied slots, 0..DEPTH
module frame_lifo
  import fspill_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       replace,
  input  logic [FRAME_W-1:0]         wdata,
  output logic [FRAME_W-1:0]         newest_c,
  output logic [FRAME_W-1:0]         oldest_c,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [FRAME_W-1:0] slots [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W-1:0]   head_prev;

  assign head_prev = head - PTR_W'(1);
  assign newest_c  = slots[head_prev];
  assign oldest_c  = slots[tail];

  // Frame storage; contents are meaningless while cnt says the slot is free.
  always_ff @(posedge clk) begin
    if (push || replace) slots[head] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (push) begin
      head <= head + PTR_W'(1);
      cnt  <= cnt + CNT_W'(1);
    end else if (pop) begin
      head <= head_prev;
      cnt  <= cnt - CNT_W'(1);
    end else if (replace) begin
      // Full store: head == tail, so the new frame lands in the freed slot.
      head <= head + PTR_W'(1);
      tail <= tail + PTR_W'(1);
    end
  end

endmodule

// File: rtl/frame_spill_unit.sv
// Frame stack with DEPTH on-chip slots that spills the oldest frame to a
// downward-growing memory area when full and refills from memory when the
// on-chip slots are empty.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   backup / restore     : push / pop request pulses (backup wins if both)
//   dataIn / dataOut     : frame pushed / last frame popped (registered)
//   busy                 : spill or fill in progress, requests ignored
//   overflow / underflow : one-cycle refusal pulses
//   mem_*                : 16-bit word memory port, read data 1 cycle after mem_re
// Optional: define FSPILL_STATS_EN to add saturating spill_count/fill_count.
module frame_spill_unit
  import fspill_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter logic [15:0] SPILL_BASE = 16'hF000,
  parameter int unsigned MAX_SPILL  = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               backup,
  input  logic               restore,
  input  logic [FRAME_W-1:0] dataIn,
  output logic [FRAME_W-1:0] dataOut,
  output logic               busy,
  output logic               overflow,
  output logic               underflow,
  output logic [15:0]        mem_addr,
  output logic [15:0]        mem_wdata,
  output logic               mem_we,
  output logic               mem_re,
  input  logic [15:0]        mem_rdata
`ifdef FSPILL_STATS_EN
  ,
  output logic [15:0]        spill_count,
  output logic [15:0]        fill_count
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned NSP_W = $clog2(MAX_SPILL + 1);
  localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(FRAME_WORDS - 1);

  state_t                     state;
  logic [NSP_W-1:0]           nsp;
  logic [WORD_IDX_W-1:0]      idx;
  logic [WORD_IDX_W-1:0]      idx_nxt;
  logic [FRAME_W-1:0]         pend;
  logic [FRAME_W-WORD_W-1:0]  fill_buf;
  mem_req_t                   mem_q;

  logic [CNT_W-1:0]           cnt;
  logic [FRAME_W-1:0]         newest_c;
  logic [FRAME_W-1:0]         oldest_c;
  logic                       full_c;
  logic                       empty_c;
  logic                       spill_room_c;
  logic                       lifo_push_c;
  logic                       lifo_pop_c;
  logic                       lifo_replace_c;
  logic [15:0]                spill_frame_c;
  logic [15:0]                fill_frame_c;

  assign full_c         = (cnt == CNT_W'(DEPTH));
  assign empty_c        = (cnt == '0);
  assign spill_room_c   = (nsp != NSP_W'(MAX_SPILL));
  assign lifo_push_c    = (state == IDLE) && backup && !full_c;
  assign lifo_pop_c     = (state == IDLE) && !backup && restore && !empty_c;
  assign lifo_replace_c = (state == PUSH);
  assign idx_nxt        = idx + WORD_IDX_W'(1);
  // Spill targets the next free memory frame, fill the topmost used one.
  assign spill_frame_c  = 16'(nsp) + 16'd1;
  assign fill_frame_c   = 16'(nsp);

  frame_lifo #(
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk      (clk),
    .reset    (reset),
    .push     (lifo_push_c),
    .pop      (lifo_pop_c),
    .replace  (lifo_replace_c),
    .wdata    (lifo_replace_c ? pend : dataIn),
    .newest_c (newest_c),
    .oldest_c (oldest_c),
    .cnt      (cnt)
  );

  assign mem_we    = mem_q.we;
  assign mem_re    = mem_q.re;
  assign mem_addr  = mem_q.addr;
  assign mem_wdata = mem_q.wdata;

  // Control FSM; memory strobes for word k are registered in the cycle
  // before they are presented, so each SPILL/FILL cycle carries one word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      nsp       <= '0;
      idx       <= '0;
      pend      <= '0;
      fill_buf  <= '0;
      dataOut   <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      mem_q     <= '0;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      case (state)
        IDLE: begin
          if (backup) begin
            if (full_c && spill_room_c) begin
              pend  <= dataIn;
              idx   <= '0;
              busy  <= 1'b1;
              state <= SPILL;
              mem_q <= '{we: 1'b1, re: 1'b0,
                         addr: spill_addr(SPILL_BASE, spill_frame_c, '0),
                         wdata: frame_word(oldest_c, '0)};
            end else if (full_c) begin
              overflow <= 1'b1;
            end
          end else if (restore) begin
            if (!empty_c) begin
              dataOut <= newest_c;
            end else if (nsp != '0) begin
              idx   <= '0;
              busy  <= 1'b1;
              state <= FILL;
              mem_q <= '{we: 1'b0, re: 1'b1,
                         addr: spill_addr(SPILL_BASE, fill_frame_c, '0),
                         wdata: 16'h0000};
            end else begin
              underflow <= 1'b1;
            end
          end
        end

        SPILL: begin
          if (idx == LAST_WORD) begin
            mem_q <= '0;
            state <= PUSH;
          end else begin
            idx         <= idx_nxt;
            mem_q.addr  <= spill_addr(SPILL_BASE, spill_frame_c, idx_nxt);
            mem_q.wdata <= frame_word(oldest_c, idx_nxt);
          end
        end

        // The store overwrites the just-spilled oldest slot with pend.
        PUSH: begin
          nsp   <= nsp + NSP_W'(1);
          busy  <= 1'b0;
          state <= IDLE;
        end

        // Read data for the word issued last cycle arrives now; shift it in
        // so word 0 ends up in the low bits.
        FILL: begin
          if (idx != '0) fill_buf <= {mem_rdata, fill_buf[FRAME_W-WORD_W-1:WORD_W]};
          if (idx == LAST_WORD) begin
            mem_q <= '0;
            state <= FILL_WAIT;
          end else begin
            idx        <= idx_nxt;
            mem_q.addr <= spill_addr(SPILL_BASE, fill_frame_c, idx_nxt);
          end
        end

        FILL_WAIT: begin
          dataOut <= {mem_rdata, fill_buf};
          nsp     <= nsp - NSP_W'(1);
          busy    <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          mem_q <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FSPILL_STATS_EN
  // Saturating completion counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      spill_count <= '0;
      fill_count  <= '0;
    end else begin
      if ((state == PUSH) && (spill_count != 16'hFFFF)) spill_count <= spill_count + 16'd1;
      if ((state == FILL_WAIT) && (fill_count != 16'hFFFF)) fill_count <= fill_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_spill_unit.sv
// Bench for frame_spill_unit: directed vector table, reset-abort and deep
// overflow sequences, and randomized operations against a queue-based model.
module tb_frame_spill_unit;

  localparam int unsigned TB_DEPTH = 4;
  localparam int unsigned TB_MAX   = 64;
  localparam logic [15:0] TB_BASE  = 16'hF000;

  typedef enum {K_NONE, K_PUSH, K_POP, K_SPILL, K_FILL, K_OVF, K_UNF} kind_t;

  typedef struct {
    logic        b;
    logic        r;
    logic [7:0]  din;
    kind_t       kind;
    logic [7:0]  out;
    logic [7:0]  mem;
    logic [15:0] base;
  } vec_t;

  logic         clk;
  logic         reset;
  logic         backup;
  logic         restore;
  logic [255:0] dataIn;
  logic [255:0] dataOut;
  logic         busy;
  logic         overflow;
  logic         underflow;
  logic [15:0]  mem_addr;
  logic [15:0]  mem_wdata;
  logic         mem_we;
  logic         mem_re;
  logic [15:0]  mem_rdata;
`ifdef FSPILL_STATS_EN
  logic [15:0]  spill_count;
  logic [15:0]  fill_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic mon_en = 1'b0;

  logic [15:0]  mem [65536];
  logic [255:0] onchip [$];
  logic [255:0] spilled [$];
  logic [255:0] last_out;
  int           m_spills;
  int           m_fills;

  frame_spill_unit #(
    .DEPTH      (TB_DEPTH),
    .SPILL_BASE (TB_BASE),
    .MAX_SPILL  (TB_MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .backup    (backup),
    .restore   (restore),
    .dataIn    (dataIn),
    .dataOut   (dataOut),
    .busy      (busy),
    .overflow  (overflow),
    .underflow (underflow),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
`ifdef FSPILL_STATS_EN
    ,
    .spill_count (spill_count),
    .fill_count  (fill_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: read data valid the cycle after mem_re, garbage otherwise.
  always @(posedge clk) begin
    if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
    if (mem_re === 1'b1) mem_rdata <= mem[mem_addr];
    else                 mem_rdata <= 16'($urandom);
  end

  // Strobe invariants checked every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_we === 1'b1 && mem_re === 1'b1) begin
        n_err++;
        $display("FAIL strobe_overlap: got we=%b re=%b, required not both high", mem_we, mem_re);
      end
      if (busy === 1'b0 && (mem_we === 1'b1 || mem_re === 1'b1)) begin
        n_err++;
        $display("FAIL idle_strobe: got we=%b re=%b with busy=0, required 0", mem_we, mem_re);
      end
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] fr(input logic [7:0] i);
    logic [255:0] f;
    f = '0;
    if (i != 8'hFF)
      for (int k = 0; k < 16; k++) f[16*k +: 16] = {i, 4'(k), 4'(15 - k)};
    return f;
  endfunction

  function automatic logic [255:0] rand_frame();
    logic [255:0] f;
    for (int j = 0; j < 8; j++) f[32*j +: 32] = $urandom;
    return f;
  endfunction

  task automatic model_clear();
    onchip.delete();
    spilled.delete();
    last_out = '0;
    m_spills = 0;
    m_fills  = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; backup = 1'b0; restore = 1'b0; dataIn = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dataOut", dataOut, '0);
    chk("rst_flags", 256'({busy, overflow, underflow}), '0);
    chk("rst_strobes", 256'({mem_we, mem_re}), '0);
    chk("rst_addr_wdata", 256'({mem_addr, mem_wdata}), '0);
    reset = 1'b0;
    mon_en = 1'b1;
    model_clear();
  endtask

  // Issue one request and check the whole resulting transaction.
  task automatic apply(input logic b, input logic r, input logic [255:0] d, input kind_t k,
                       input logic [255:0] exp_out, input logic [255:0] exp_mem,
                       input logic [15:0] base);
    int cyc;
    int nstb;
    logic ok;
    logic [15:0] w;
    backup = b; restore = r; dataIn = d;
    @(posedge clk);
    #1;
    backup = 1'b0; restore = 1'b0; dataIn = rand_frame();
    if (k == K_SPILL || k == K_FILL) begin
      cyc = 0; nstb = 0; ok = 1'b1;
      while (busy === 1'b1 && cyc < 40) begin
        cyc++;
        if (mem_we === 1'b1) begin
          if (k != K_SPILL || nstb >= 16) ok = 1'b0;
          else begin
            w = exp_mem[16*nstb +: 16];
            if (mem_addr !== base + 16'(nstb) || mem_wdata !== w) ok = 1'b0;
          end
          nstb++;
        end
        if (mem_re === 1'b1) begin
          if (k != K_FILL || mem_addr !== base + 16'(nstb)) ok = 1'b0;
          nstb++;
        end
        if (overflow !== 1'b0 || underflow !== 1'b0) ok = 1'b0;
        // Requests while busy must be ignored.
        backup = 1'($urandom); restore = 1'($urandom);
        @(posedge clk);
        #1;
      end
      backup = 1'b0; restore = 1'b0;
      chk("busy_cycles", 256'(cyc), 256'(17));
      chk("strobe_count", 256'(nstb), 256'(16));
      chk("strobe_addr_data", 256'(ok), 256'(1));
      chk("xfer_dataOut", dataOut, exp_out);
    end else begin
      chk("busy", 256'(busy), '0);
      chk("overflow", 256'(overflow), 256'(k == K_OVF));
      chk("underflow", 256'(underflow), 256'(k == K_UNF));
      chk("dataOut", dataOut, exp_out);
      chk("strobes", 256'({mem_we, mem_re}), '0);
    end
    @(posedge clk);
    #1;
    chk("pulse_end", 256'({busy, overflow, underflow}), '0);
    chk("dataOut_hold", dataOut, exp_out);
  endtask

  // Reference model: on-chip queue (oldest at front) and memory stack.
  task automatic model_op(input logic b, input logic r, input logic [255:0] d);
    kind_t        k;
    logic [255:0] f;
    logic [15:0]  base;
    f = '0; base = '0; k = K_NONE;
    if (b) begin
      if (onchip.size() < TB_DEPTH) begin
        k = K_PUSH;
        onchip.push_back(d);
      end else if (spilled.size() < TB_MAX) begin
        k = K_SPILL;
        f = onchip.pop_front();
        spilled.push_back(f);
        onchip.push_back(d);
        base = TB_BASE - 16'(16 * spilled.size());
        m_spills++;
      end else begin
        k = K_OVF;
      end
    end else if (r) begin
      if (onchip.size() > 0) begin
        k = K_POP;
        last_out = onchip.pop_back();
      end else if (spilled.size() > 0) begin
        k = K_FILL;
        base = TB_BASE - 16'(16 * spilled.size());
        last_out = spilled.pop_back();
        m_fills++;
      end else begin
        k = K_UNF;
      end
    end
    apply(b, r, d, k, last_out, f, base);
  endtask

  localparam int NV = 21;
  vec_t tbl [NV];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'd0,   K_PUSH,  8'hFF, 8'hFF, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 8'd1,   K_PUSH,  8'hFF, 8'hFF, 16'h0000};
    tbl[2]  = '{1'b1, 1'b1, 8'd2,   K_PUSH,  8'hFF, 8'hFF, 16'h0000};
    tbl[3]  = '{1'b1, 1'b0, 8'd3,   K_PUSH,  8'hFF, 8'hFF, 16'h0000};
    tbl[4]  = '{1'b0, 1'b1, 8'hFF,  K_POP,   8'd3,  8'hFF, 16'h0000};
    tbl[5]  = '{1'b0, 1'b1, 8'hFF,  K_POP,   8'd2,  8'hFF, 16'h0000};
    tbl[6]  = '{1'b0, 1'b1, 8'hFF,  K_POP,   8'd1,  8'hFF, 16'h0000};
    tbl[7]  = '{1'b0, 1'b1, 8'hFF,  K_POP,   8'd0,  8'hFF, 16'h0000};
    tbl[8]  = '{1'b0, 1'b1, 8'hFF,  K_UNF,   8'd0,  8'hFF, 16'h0000};
    tbl[9]  = '{1'b1, 1'b0, 8'd0,   K_PUSH,  8'd0,  8'hFF, 16'h0000};
    tbl[10] = '{1'b1, 1'b0, 8'd1,   K_PUSH,  8'd0,  8'hFF, 16'h0000};
    tbl[11] = '{1'b1, 1'b0, 8'd2,   K_PUSH,  8'd0,  8'hFF, 16'h0000};
    tbl[12] = '{1'b1, 1'b0, 8'd3,   K_PUSH,  8'd0,  8'hFF, 16'h0000};
    tbl[13] = '{1'b1, 1'b0, 8'd4,   K_SPILL, 8'd0,  8'd0,  16'hEFF0};
    tbl[14] = '{1'b0, 1'b1, 8'hFF,  K_POP,   8'd4,  8'hFF, 16'h0000};
    tbl[15] = '{1'b0, 1'b1, 8'hFF,  K_POP,   8'd3,  8'hFF, 16'h0000};
    tbl[16] = '{1'b0, 1'b1, 8'hFF,  K_POP,   8'd2,  8'hFF, 16'h0000};
    tbl[17] = '{1'b0, 1'b1, 8'hFF,  K_POP,   8'd1,  8'hFF, 16'h0000};
    tbl[18] = '{1'b0, 1'b1, 8'hFF,  K_FILL,  8'd0,  8'hFF, 16'hEFF0};
    tbl[19] = '{1'b0, 1'b1, 8'hFF,  K_UNF,   8'd0,  8'hFF, 16'h0000};
    tbl[20] = '{1'b0, 1'b0, 8'hFF,  K_NONE,  8'd0,  8'hFF, 16'h0000};

    do_reset();
    for (int i = 0; i < NV; i++)
      apply(tbl[i].b, tbl[i].r, fr(tbl[i].din), tbl[i].kind, fr(tbl[i].out),
            fr(tbl[i].mem), tbl[i].base);

    // Fill the whole spill area, hit overflow, then drain to underflow.
    do_reset();
    for (int i = 0; i < TB_DEPTH + TB_MAX; i++) model_op(1'b1, 1'b0, rand_frame());
    model_op(1'b1, 1'b0, rand_frame());
    for (int i = 0; i < TB_DEPTH + TB_MAX + 1; i++) model_op(1'b0, 1'b1, '0);

    // Reset in the 8th spill write cycle aborts everything.
    do_reset();
    for (int i = 0; i < TB_DEPTH; i++) model_op(1'b1, 1'b0, rand_frame());
    backup = 1'b1; dataIn = rand_frame();
    @(posedge clk);
    #1;
    backup = 1'b0;
    for (int c = 1; c < 8; c++) begin
      @(posedge clk);
      #1;
    end
    chk("abort_spill_active", 256'({busy, mem_we, mem_addr}), 256'({2'b11, 16'hEFF7}));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_strobes", 256'({mem_we, mem_re, busy}), '0);
    chk("abort_dataOut", dataOut, '0);
    chk("abort_addr", 256'({mem_addr, mem_wdata}), '0);
    model_clear();
    model_op(1'b0, 1'b1, '0);
    for (int i = 0; i < TB_DEPTH + 1; i++) model_op(1'b1, 1'b0, rand_frame());
    for (int i = 0; i < TB_DEPTH + 2; i++) model_op(1'b0, 1'b1, '0);

    // Randomized operation mix.
    do_reset();
    for (int i = 0; i < 250; i++) begin
      int   sel;
      logic b;
      logic r;
      sel = $urandom_range(0, 99);
      b = (sel < 55);
      r = (sel >= 48 && sel < 96);
      model_op(b, r, rand_frame());
    end
`ifdef FSPILL_STATS_EN
    chk("spill_count", 256'(spill_count), 256'(m_spills));
    chk("fill_count", 256'(fill_count), 256'(m_fills));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
